// File: rtl/fsm_ctrl_p.sv
// Multicycle fetch/execute/memory/writeback controller for the CR16-style datapath.
// Owns PC, IR and PSR; BRAM read latency is set by MEM_LAT.
module fsm_ctrl_p #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_dout,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    input  logic [DATA_W-1:0] dmem_dout,
    output logic [3:0]        rf_ra_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    output logic [3:0]        rf_rb_addr,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        alu_flags,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [4:0]        psr_out,
    output logic [2:0]        state_out,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd7
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [4:0]        r_psr;
    logic [2:0]        r_cnt;

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_ext;
    logic [3:0]        w_rs;
    logic              w_is_alu;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_j;
    logic              w_is_b;
    logic              w_is_halt;
    logic              w_cond;
    logic              w_last;
    logic signed [7:0] w_disp8;
    logic [ADDR_W-1:0] w_disp;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_br;
    logic [ADDR_W-1:0] w_rb_addr;
    logic              w_unused_rb;

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:8];
    assign w_ext     = r_ir[7:4];
    assign w_rs      = r_ir[3:0];
    assign w_is_alu  = (w_op == 4'h0);
    assign w_is_ld   = (w_op == 4'h4) && (w_ext == 4'h0);
    assign w_is_st   = (w_op == 4'h4) && (w_ext == 4'h4);
    assign w_is_j    = (w_op == 4'h4) && (w_ext == 4'hC);
    assign w_is_b    = (w_op == 4'hC);
    assign w_is_halt = (w_op == 4'hF);

    assign w_last    = (r_cnt == 3'(MEM_LAT - 1));
    assign w_disp8   = r_ir[7:0];
    assign w_disp    = ADDR_W'(w_disp8);
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_pc_br   = r_pc + w_disp;
    assign w_rb_addr = rf_rb_data[ADDR_W-1:0];
    assign w_unused_rb = &{1'b0, rf_rb_data[DATA_W-1:ADDR_W]};

    // Condition field (rd) tested against PSR {N,F,Z,L,C}
    always_comb begin
        w_cond = 1'b0;
        case (w_rd)
            4'h0:    w_cond = r_psr[2];
            4'h1:    w_cond = !r_psr[2];
            4'h2:    w_cond = r_psr[0];
            4'h3:    w_cond = !r_psr[0];
            4'h4:    w_cond = r_psr[1];
            4'h5:    w_cond = !r_psr[1];
            4'h6:    w_cond = r_psr[4];
            4'h7:    w_cond = !r_psr[4];
            4'h8:    w_cond = r_psr[3];
            4'h9:    w_cond = !r_psr[3];
            4'hE:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_psr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_cnt   <= '0;
                    r_state <= S_FWAIT;
                end
                S_FWAIT: begin
                    if (w_last) begin
                        r_ir    <= imem_dout;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        w_is_alu: begin
                            r_psr   <= alu_flags;
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        w_is_ld, w_is_st: r_state <= S_MEM;
                        w_is_j: begin
                            r_pc    <= w_cond ? w_rb_addr : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        w_is_b: begin
                            r_pc    <= w_cond ? w_pc_br : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        w_is_halt: r_state <= S_HALT;
                        default: begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (w_is_st) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (w_last) r_state <= S_WB;
                    else        r_cnt   <= r_cnt + 3'd1;
                end
                S_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_en    = !rst && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_en    = !rst && (r_state == S_MEM);
    assign dmem_we    = dmem_en && w_is_st;
    assign dmem_addr  = w_rb_addr;
    assign dmem_din   = dmem_we ? rf_ra_data : '0;
    assign rf_ra_addr = w_rd;
    assign rf_rb_addr = w_rs;
    assign rf_waddr   = w_rd;
    assign rf_we      = !rst && (((r_state == S_EXEC) && w_is_alu) ||
                                 (r_state == S_WB));
    assign rf_wdata   = !rf_we ? '0 :
                        ((r_state == S_WB) ? dmem_dout : alu_out);
    assign alu_op     = {1'b0, w_ext};
    assign pc_out     = r_pc;
    assign ir_out     = r_ir;
    assign psr_out    = r_psr;
    assign state_out  = r_state;
    assign halted     = !rst && (r_state == S_HALT);

endmodule

// File: doc/fsm_ctrl_p.md
Name: fsm_ctrl_p

Overview:
- Parametrised multicycle control unit for the 16-bit CR16-style datapath. It is the next generation of the stage-3 controller.
- The PC, IR and a processor-flags (PSR) register move inside the block.
- Fetch/data memory read latency is configurable, and the block adds a HALT state.
- It sits between the instruction/data BRAMs, the register file and the ALU, and sequences fetch/execute/memory/writeback.

Parameters:
DATA_W, 16, datapath and instruction width (instruction fields below assume 16)
ADDR_W, 9, PC and memory address width (must be >= 8)
MEM_LAT, 1, BRAM read latency in cycles (1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
imem_en  out  1  instruction memory read enable
imem_addr  out  ADDR_W  instruction address (= PC)
imem_dout  in  DATA_W  instruction read data
dmem_en  out  1  data memory enable
dmem_we  out  1  data memory write enable
dmem_addr  out  ADDR_W  data address
dmem_din  out  DATA_W  data memory write data
dmem_dout  in  DATA_W  data memory read data
rf_ra_addr  out  4  read port A address (IR[11:8], Rdest)
rf_ra_data  in  DATA_W  port A data
rf_rb_addr  out  4  read port B address (IR[3:0], Rsrc)
rf_rb_data  in  DATA_W  port B data
rf_we  out  1  register file write enable
rf_waddr  out  4  write address (always IR[11:8])
rf_wdata  out  DATA_W  write data
alu_op  out  5  {1'b0, IR[7:4]}
alu_out  in  DATA_W  ALU result
alu_flags  in  5  ALU flags {N,F,Z,L,C} = bits [4:0] in the order [4]N [3]F [2]Z [1]L [0]C
pc_out  out  ADDR_W  current PC
ir_out  out  DATA_W  current IR
psr_out  out  5  latched flags
state_out  out  3  current state encoding
halted  out  1  high in HALT

Behaviour:
- Reset (rst high at clk edge):
  - state <= FETCH; pc, ir, psr, wait counter <= 0.
  - While rst is high, all strobes (imem_en, dmem_en, dmem_we, rf_we) are forced 0.
  - halted = 0.
  - Reset mid-instruction aborts it with no write.
- State encodings: FETCH=0, FWAIT=1, EXEC=2, MEM=3, MWAIT=4, WB=5, HALT=7.
- All strobes and addresses are combinational from state, IR and the PC/PSR registers.
- Decode: op=IR[15:12], rd=IR[11:8], ext=IR[7:4], rs=IR[3:0].
  - op 0000: ALU R-type.
  - op 0100 ext 0000: LOAD rd <- M[rs].
  - op 0100 ext 0100: STOR M[rs] <- rd.
  - op 0100 ext 1100: Jcond (cond=rd field, target=rs).
  - op 1100: Bcond (cond=IR[11:8], disp=IR[7:0] sign-extended to ADDR_W).
  - op 1111: HALT.
  - Anything else: NOP.
- FETCH: imem_en=1, imem_addr=pc. Clear the wait counter, then go to FWAIT.
- FWAIT: stays for exactly MEM_LAT cycles. On the edge ending the last one, ir <= imem_dout, then go to EXEC.
- EXEC, by instruction:
  - ALU: rf_we=1, rf_wdata=alu_out, psr <= alu_flags, pc <= pc+1, then FETCH.
  - LOAD/STOR: go to MEM. PC is unchanged.
  - Jcond: if the condition is true, pc <= rf_rb_data[ADDR_W-1:0]; else pc <= pc+1. Then FETCH.
  - Bcond: if the condition is true, pc <= pc+disp; else pc <= pc+1. Then FETCH.
  - NOP: pc <= pc+1, then FETCH.
  - HALT: go to HALT.
- MEM: dmem_en=1, dmem_addr=rf_rb_data[ADDR_W-1:0].
  - STOR: dmem_we=1, dmem_din=rf_ra_data, pc <= pc+1, then FETCH.
  - LOAD: dmem_we=0, then MWAIT.
- MWAIT: stays for MEM_LAT cycles, then WB.
- WB: rf_we=1, rf_wdata=dmem_dout, pc <= pc+1, then FETCH.
- HALT: no strobes; halted=1; stays until rst.
- Latency:
  - ALU/branch/jump/NOP: MEM_LAT+2 cycles.
  - STOR: MEM_LAT+3 cycles.
  - LOAD: 2*MEM_LAT+4 cycles.
- Conditions on psr (flags from the last ALU op; a LOAD does not change psr):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N.
  - 1000 FS F; 1001 FC !F; 1110 UC always.
  - Others: never.
- Arithmetic: all PC math is modulo 2^ADDR_W. pc = 2^ADDR_W-1 plus 1 wraps to 0; negative displacements wrap as well.
- rf_ra_addr/rf_rb_addr are driven from the IR in all states. rf_wdata=0 when rf_we=0.

Test Plan:
- Reset and fetch: hold rst 2 cycles, release; with MEM_LAT=1 -> FETCH has imem_en=1 and imem_addr=0; IR is loaded after 1 FWAIT cycle; state_out sequence is 0,1,2.
- ALU: IR=0x0152 (ADD r1,r5... rd=1, ext=5, rs=2), alu_out=0x0007, alu_flags=5'b00100 -> in EXEC rf_we=1, rf_waddr=1, rf_wdata=0x0007, alu_op=5'h05; next cycle psr=5'b00100 and pc=1.
- LOAD with MEM_LAT=3: IR=0x4203, rf_rb_data=0x0011, dmem_dout=0x00FF -> in MEM dmem_en=1, dmem_we=0, dmem_addr=0x011; after 3 MWAIT cycles WB has rf_we=1, rf_waddr=2, rf_wdata=0x00FF; total 10 cycles.
- STOR: IR=0x4243, rf_ra_data=0x00AA, rf_rb_data=0x0020 -> in MEM dmem_we=1, dmem_addr=0x020, dmem_din=0x00AA; no rf_we at any point.
- Branch: psr.Z=1, pc=0x005, IR=0xC0FC (BEQ -4) -> pc=0x001. Repeat with Z=0 -> pc=0x006. Then pc=0x1FF with IR=0xCE01 (UC +1) -> pc wraps to 0x000.
- HALT and reset mid-op: IR=0xF000 -> halted=1 and no strobes for 20 cycles. Separately, assert rst during MWAIT of a LOAD -> no rf_we, state=FETCH, pc=0.
